joystick_drive: RTL and testbench
=================================

// Module: joystick_drive
// PURPOSE
//  Consumes the 12-bit joystick channels produced by the ADC interface (X on CH0, Y on CH1).
//  Samples them at a fixed rate, averages, calibrates centre, applies a deadzone and
//  arcade-mixes X/Y into signed left/right motor commands (duty + direction) for the PWM stage.
// PARAMETERS
//  SAMPLE_DIV  50000  CLOCK cycles per sample tick (1 kHz @ 50 MHz); must be >= 4
//  AVG_LOG2    2      log2 of samples averaged per command and per calibration
//  DEADZONE    200    half-width of centre deadzone, in ADC LSBs
//  PWM_BITS    8      duty output width (1..11)
// PORTS
//  CLOCK       in   1         system clock
//  RESET       in   1         asynchronous, active-low reset
//  X_IN        in   12        joystick X, unsigned ADC code (CH0)
//  Y_IN        in   12        joystick Y, unsigned ADC code (CH1)
//  CAL         in   1         recalibration request, level-sampled each cycle
//  LEFT_DUTY   out  PWM_BITS  left motor duty magnitude
//  RIGHT_DUTY  out  PWM_BITS  right motor duty magnitude
//  LEFT_DIR    out  1         1 = forward, 0 = reverse
//  RIGHT_DIR   out  1         1 = forward, 0 = reverse
//  CMD_VALID   out  1         one-cycle pulse when new duty/dir values are registered
//  CAL_DONE    out  1         high once a centre has been captured
// BEHAVIOUR
//  Reset: duties 0, dirs 1, CMD_VALID 0, CAL_DONE 0, centres 2048, tick counter 0, state CAL_ACC.
//  Tick: counter 0..SAMPLE_DIV-1, tick on SAMPLE_DIV-1, then wraps to 0; free-running in all states.
//  FSM states: CAL_ACC, RUN_ACC, COMPUTE, OUTPUT.
//  *_ACC: on tick, acc_x += X_IN, acc_y += Y_IN (width 12+AVG_LOG2), cnt++.
//    The tick adding sample 2^AVG_LOG2 ends the block; acc/cnt clear on the next cycle.
//  CAL_ACC -> RUN_ACC at block end: centre = acc >> AVG_LOG2; CAL_DONE = 1 on the next cycle.
//  RUN_ACC -> COMPUTE at block end. COMPUTE (1 cycle) registers per axis:
//    off = avg - centre (signed 13b);
//    |off| <= DEADZONE -> 0, else off - sign(off)*DEADZONE.
//  OUTPUT (1 cycle) registers left = y + x, right = y - x (signed 14b),
//    saturated to [-2047, +2047];
//    DIR = (v >= 0); DUTY = |v| >> (11-PWM_BITS); CMD_VALID = 1 this cycle only.
//    Returns to RUN_ACC.
//  Latency: CMD_VALID asserts 3 cycles after the block-ending tick.
//  SAMPLE_DIV >= 4 guarantees no tick occurs during COMPUTE/OUTPUT.
//  CAL = 1 in any state: next cycle enters CAL_ACC, clears acc/cnt and CAL_DONE,
//    forces both duties to 0 and dirs to 1, with no CMD_VALID pulse;
//    any in-flight computation is discarded.
//    CAL held high keeps restarting accumulation; calibration completes after release.
//  CAL and block-end tick in the same cycle: CAL wins and the sample is dropped.
//  Duties stay 0 from reset until the first RUN command, so the motors never move uncalibrated.
//  Async reset mid-operation returns every register to its reset value immediately.
// STRUCTURE
//  joystick_pkg: state enum, ADC_W = 12, CENTRE_DEFAULT = 12'd2048, MIX_MAX = 2047,
//    sat14to12 function.
//  Sub-module joystick_axis, instantiated x2: accumulator, centre register,
//    offset and deadzone.
//  Top: tick counter, FSM, mixer, saturation and output registers.
// TESTING (SAMPLE_DIV=8, AVG_LOG2=2, DEADZONE=200, PWM_BITS=8)
//  1. Reset, X=Y=2048 for 4 ticks -> CAL_DONE=1, centre 2048;
//     next block -> CMD_VALID pulse, duties 0/0, dirs 1/1.
//  2. Calibrated at 2048; Y=4095, X=2048 -> off_y=1847;
//     L=R=1847 -> duties 230/230, dirs 1/1.
//  3. X=4095, Y=2048 -> LEFT 230 dir 1, RIGHT 230 dir 0.
//  4. X=Y=4095 -> left 3694 saturates -> LEFT_DUTY 255 dir 1; RIGHT_DUTY 0 dir 1.
//  5. Deadzone: Y=2248 -> duties 0; Y=2264 -> off 16 -> duties 2/2;
//     Y=1832 -> duties 2/2, dirs 0/0.
//  6. In RUN with duties non-zero, pulse CAL with X=Y=1000 -> next cycle duties 0, CAL_DONE 0;
//     after 4 ticks CAL_DONE=1, centre 1000; X=Y=1000 -> duties 0.
//     Then assert RESET mid-block -> all outputs at reset values.

Source files
------------

// File: rtl/joystick_pkg.sv
// ============================================================================
// joystick_pkg : shared types, constants and mixer saturation helper
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package joystick_pkg;

    typedef enum logic [1:0] {
        ST_CAL_ACC = 2'd0,
        ST_RUN_ACC = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_e;

    localparam int               ADC_W          = 12;
    localparam logic [ADC_W-1:0] CENTRE_DEFAULT = 12'd2048;
    localparam int               MIX_MAX        = 2047;

    function automatic logic signed [ADC_W-1:0] sat14to12(input logic signed [ADC_W+1:0] v);
        logic signed [ADC_W-1:0] r;
        if (int'(v) > MIX_MAX) begin
            r = ADC_W'(MIX_MAX);
        end else if (int'(v) < -MIX_MAX) begin
            r = ADC_W'(-MIX_MAX);
        end else begin
            r = v[ADC_W-1:0];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/joystick_axis.sv
// ============================================================================
// joystick_axis : per-axis sample accumulator, centre register and deadzone
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module joystick_axis
    import joystick_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int DEADZONE = 200
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADC_W-1:0]      sample_i,
    input  logic                  acc_en_i,
    input  logic                  acc_clr_i,
    input  logic                  centre_ld_i,
    input  logic                  comp_i,
    output logic signed [ADC_W:0] dz_o
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int OFF_W = ADC_W + 1;
    localparam logic signed [OFF_W-1:0] DZ = OFF_W'(DEADZONE);

    logic [ACC_W-1:0]        acc_q, acc_d, w_sum;
    logic [ADC_W-1:0]        centre_q, centre_d, w_avg, w_sum_avg;
    logic signed [OFF_W-1:0] w_off, dz_q, dz_d;

    // The accumulator never overflows: 2^AVG_LOG2 full-scale codes fit ACC_W.
    assign w_sum     = acc_q + ACC_W'(sample_i);
    assign w_sum_avg = w_sum[ACC_W-1:AVG_LOG2];
    assign w_avg     = acc_q[ACC_W-1:AVG_LOG2];
    assign w_off     = $signed({1'b0, w_avg}) - $signed({1'b0, centre_q});

    always_comb begin
        acc_d    = acc_q;
        centre_d = centre_q;
        dz_d     = dz_q;
        if (acc_clr_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = w_sum;
        end
        if (centre_ld_i) begin
            centre_d = w_sum_avg;
        end
        if (comp_i) begin
            if (w_off > DZ) begin
                dz_d = w_off - DZ;
            end else if (w_off < -DZ) begin
                dz_d = w_off + DZ;
            end else begin
                dz_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            centre_q <= CENTRE_DEFAULT;
            dz_q     <= '0;
        end else begin
            acc_q    <= acc_d;
            centre_q <= centre_d;
            dz_q     <= dz_d;
        end
    end

    assign dz_o = dz_q;

endmodule

`default_nettype wire

// File: rtl/joystick_drive.sv
// ============================================================================
// joystick_drive : joystick sampling, calibration and arcade mix to motor cmds
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module joystick_drive
    import joystick_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000,
    parameter int AVG_LOG2   = 2,
    parameter int DEADZONE   = 200,
    parameter int PWM_BITS   = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ADC_W-1:0]    x_i,
    input  logic [ADC_W-1:0]    y_i,
    input  logic                cal_i,
    output logic [PWM_BITS-1:0] left_duty_o,
    output logic [PWM_BITS-1:0] right_duty_o,
    output logic                left_dir_o,
    output logic                right_dir_o,
    output logic                cmd_valid_o,
    output logic                cal_done_o
);

    localparam int                TICK_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam int                CNT_W     = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam int                MAG_W     = ADC_W - 1;
    localparam int                SHIFT     = MAG_W - PWM_BITS;

    state_e                  state_q, state_d;
    logic [TICK_W-1:0]       tick_q, tick_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    w_tick, w_sample, w_block_end;
    logic                    w_acc_en, w_acc_clr, w_centre_ld, w_comp, w_out_ld;
    logic signed [ADC_W:0]   w_dz_x, w_dz_y;
    logic signed [ADC_W+1:0] w_mix_l, w_mix_r;
    logic signed [ADC_W-1:0] w_sat_l, w_sat_r;
    logic [MAG_W-1:0]        w_mag_l, w_mag_r;
    logic [PWM_BITS-1:0]     left_duty_q, left_duty_d, right_duty_q, right_duty_d;
    logic                    left_dir_q, left_dir_d, right_dir_q, right_dir_d;
    logic                    cmd_valid_q, cmd_valid_d, cal_done_q, cal_done_d;

    assign w_tick      = (tick_q == TICK_LAST);
    assign tick_d      = w_tick ? '0 : tick_q + TICK_W'(1);
    // CAL beats a coincident tick, so that sample is never accumulated.
    assign w_sample    = w_tick && !cal_i &&
                         (state_q == ST_CAL_ACC || state_q == ST_RUN_ACC);
    assign w_block_end = w_sample && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_CAL_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cal_i) begin
            state_d = ST_CAL_ACC;
        end else begin
            case (state_q)
                ST_CAL_ACC: if (w_block_end) state_d = ST_RUN_ACC;
                ST_RUN_ACC: if (w_block_end) state_d = ST_COMPUTE;
                ST_COMPUTE: state_d = ST_OUTPUT;
                ST_OUTPUT:  state_d = ST_RUN_ACC;
                default:    state_d = ST_CAL_ACC;
            endcase
        end
    end

    always_comb begin
        w_acc_en    = w_sample;
        w_centre_ld = w_block_end && (state_q == ST_CAL_ACC);
        w_comp      = (state_q == ST_COMPUTE);
        w_out_ld    = (state_q == ST_OUTPUT) && !cal_i;
        w_acc_clr   = cal_i || w_comp || w_centre_ld;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (w_acc_clr) begin
            cnt_d = '0;
        end else if (w_acc_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    joystick_axis #(.AVG_LOG2(AVG_LOG2), .DEADZONE(DEADZONE)) u_axis_x (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sample_i    (x_i),
        .acc_en_i    (w_acc_en),
        .acc_clr_i   (w_acc_clr),
        .centre_ld_i (w_centre_ld),
        .comp_i      (w_comp),
        .dz_o        (w_dz_x)
    );

    joystick_axis #(.AVG_LOG2(AVG_LOG2), .DEADZONE(DEADZONE)) u_axis_y (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sample_i    (y_i),
        .acc_en_i    (w_acc_en),
        .acc_clr_i   (w_acc_clr),
        .centre_ld_i (w_centre_ld),
        .comp_i      (w_comp),
        .dz_o        (w_dz_y)
    );

    assign w_mix_l = {w_dz_y[ADC_W], w_dz_y} + {w_dz_x[ADC_W], w_dz_x};
    assign w_mix_r = {w_dz_y[ADC_W], w_dz_y} - {w_dz_x[ADC_W], w_dz_x};
    assign w_sat_l = sat14to12(w_mix_l);
    assign w_sat_r = sat14to12(w_mix_r);
    assign w_mag_l = w_sat_l[ADC_W-1] ? MAG_W'(-w_sat_l) : w_sat_l[MAG_W-1:0];
    assign w_mag_r = w_sat_r[ADC_W-1] ? MAG_W'(-w_sat_r) : w_sat_r[MAG_W-1:0];

    always_comb begin
        left_duty_d  = left_duty_q;
        right_duty_d = right_duty_q;
        left_dir_d   = left_dir_q;
        right_dir_d  = right_dir_q;
        cmd_valid_d  = w_out_ld;
        cal_done_d   = cal_done_q;
        if (cal_i) begin
            left_duty_d  = '0;
            right_duty_d = '0;
            left_dir_d   = 1'b1;
            right_dir_d  = 1'b1;
            cal_done_d   = 1'b0;
        end else begin
            if (w_out_ld) begin
                left_duty_d  = PWM_BITS'(w_mag_l >> SHIFT);
                right_duty_d = PWM_BITS'(w_mag_r >> SHIFT);
                left_dir_d   = !w_sat_l[ADC_W-1];
                right_dir_d  = !w_sat_r[ADC_W-1];
            end
            if (w_centre_ld) begin
                cal_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_q       <= '0;
            cnt_q        <= '0;
            left_duty_q  <= '0;
            right_duty_q <= '0;
            left_dir_q   <= 1'b1;
            right_dir_q  <= 1'b1;
            cmd_valid_q  <= 1'b0;
            cal_done_q   <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            cnt_q        <= cnt_d;
            left_duty_q  <= left_duty_d;
            right_duty_q <= right_duty_d;
            left_dir_q   <= left_dir_d;
            right_dir_q  <= right_dir_d;
            cmd_valid_q  <= cmd_valid_d;
            cal_done_q   <= cal_done_d;
        end
    end

    assign left_duty_o  = left_duty_q;
    assign right_duty_o = right_duty_q;
    assign left_dir_o   = left_dir_q;
    assign right_dir_o  = right_dir_q;
    assign cmd_valid_o  = cmd_valid_q;
    assign cal_done_o   = cal_done_q;

endmodule

`default_nettype wire

// File: tb/tb_joystick_drive.sv
// ============================================================================
// tb_joystick_drive : directed self-checking bench for joystick_drive
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_joystick_drive;

    localparam int PB = 8;

    logic          clk_i  = 1'b0;
    logic          rst_ni = 1'b0;
    logic          cal_i  = 1'b0;
    logic [11:0]   x_i    = 12'd2048;
    logic [11:0]   y_i    = 12'd2048;
    logic [PB-1:0] left_duty, right_duty;
    logic          left_dir, right_dir, cmd_valid, cal_done;

    int total = 0;
    int bad   = 0;
    int n;
    int seen_cmd;

    always #5 clk_i = ~clk_i;

    joystick_drive #(
        .SAMPLE_DIV (8),
        .AVG_LOG2   (2),
        .DEADZONE   (200),
        .PWM_BITS   (PB)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .x_i          (x_i),
        .y_i          (y_i),
        .cal_i        (cal_i),
        .left_duty_o  (left_duty),
        .right_duty_o (right_duty),
        .left_dir_o   (left_dir),
        .right_dir_o  (right_dir),
        .cmd_valid_o  (cmd_valid),
        .cal_done_o   (cal_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Returns the number of falling edges until CMD_VALID is seen (bounded).
    task automatic wait_cmd(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk_i);
            cycles++;
        end while (cmd_valid !== 1'b1 && cycles < 200);
        if (cmd_valid !== 1'b1) begin
            total++;
            bad++;
            $error("FAIL cmd_timeout: observed=no_pulse expected=pulse");
        end
    endtask

    task automatic wait_cal(output int cycles, output int cmds);
        cycles = 0;
        cmds   = 0;
        do begin
            @(negedge clk_i);
            cycles++;
            if (cmd_valid === 1'b1) cmds++;
        end while (cal_done !== 1'b1 && cycles < 200);
        check("cal_done_rise", 32'(cal_done), 32'd1);
    endtask

    task automatic expect_cmd(input string tag, input int ld, input int rd,
                              input logic ldir, input logic rdir);
        int c;
        wait_cmd(c);
        check({tag, "_ldut"}, 32'(left_duty), 32'(ld));
        check({tag, "_rdut"}, 32'(right_duty), 32'(rd));
        check({tag, "_ldir"}, 32'(left_dir), 32'(ldir));
        check({tag, "_rdir"}, 32'(right_dir), 32'(rdir));
        @(negedge clk_i);
        check({tag, "_pulse1"}, 32'(cmd_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_ldut", 32'(left_duty), 32'd0);
        check("rst_rdut", 32'(right_duty), 32'd0);
        check("rst_ldir", 32'(left_dir), 32'd1);
        check("rst_rdir", 32'(right_dir), 32'd1);
        check("rst_cmd", 32'(cmd_valid), 32'd0);
        check("rst_cal", 32'(cal_done), 32'd0);

        // 1: calibrate at 2048, first command is all-stop
        rst_ni = 1'b1;
        wait_cal(n, seen_cmd);
        check("cal1_no_cmd", 32'(seen_cmd), 32'd0);
        check("cal1_stop_ldut", 32'(left_duty), 32'd0);
        wait_cmd(n);
        check("latency_cal_to_cmd", 32'(n), 32'd34);
        check("t1_ldut", 32'(left_duty), 32'd0);
        check("t1_rdut", 32'(right_duty), 32'd0);
        check("t1_ldir", 32'(left_dir), 32'd1);
        check("t1_rdir", 32'(right_dir), 32'd1);
        @(negedge clk_i);
        check("t1_pulse1", 32'(cmd_valid), 32'd0);

        // 2: full forward
        y_i = 12'd4095; x_i = 12'd2048;
        expect_cmd("t2", 230, 230, 1'b1, 1'b1);
        // 3: full right turn
        y_i = 12'd2048; x_i = 12'd4095;
        expect_cmd("t3", 230, 230, 1'b1, 1'b0);
        // 4: left saturates
        y_i = 12'd4095; x_i = 12'd4095;
        expect_cmd("t4", 255, 0, 1'b1, 1'b1);
        // 5: deadzone edges
        x_i = 12'd2048; y_i = 12'd2248;
        expect_cmd("t5a", 0, 0, 1'b1, 1'b1);
        y_i = 12'd2264;
        expect_cmd("t5b", 2, 2, 1'b1, 1'b1);
        y_i = 12'd1832;
        expect_cmd("t5c", 2, 2, 1'b0, 1'b0);

        // 6: recalibrate at 1000 while driving
        y_i = 12'd4095;
        expect_cmd("t6pre", 230, 230, 1'b1, 1'b1);
        x_i = 12'd1000; y_i = 12'd1000; cal_i = 1'b1;
        @(negedge clk_i);
        cal_i = 1'b0;
        check("t6_cal_ldut", 32'(left_duty), 32'd0);
        check("t6_cal_rdut", 32'(right_duty), 32'd0);
        check("t6_cal_ldir", 32'(left_dir), 32'd1);
        check("t6_cal_done", 32'(cal_done), 32'd0);
        check("t6_cal_cmd", 32'(cmd_valid), 32'd0);
        wait_cal(n, seen_cmd);
        check("t6_no_cmd", 32'(seen_cmd), 32'd0);
        expect_cmd("t6_centre", 0, 0, 1'b1, 1'b1);
        y_i = 12'd1300;
        expect_cmd("t6_fwd", 12, 12, 1'b1, 1'b1);

        // Asynchronous reset mid-block
        y_i = 12'd4095;
        repeat (5) @(negedge clk_i);
        check("t6b_pre_ldut", 32'(left_duty), 32'd12);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_ldut", 32'(left_duty), 32'd0);
        check("arst_rdut", 32'(right_duty), 32'd0);
        check("arst_ldir", 32'(left_dir), 32'd1);
        check("arst_rdir", 32'(right_dir), 32'd1);
        check("arst_cmd", 32'(cmd_valid), 32'd0);
        check("arst_cal", 32'(cal_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
